data_skid_reg: RTL

- Parametrised successor to the fixed 32-bit enable register.
- A WIDTH-bit, two-entry pipeline register (main + skid) with valid/ready handshake on both sides and synchronous flush.
- Sits between CPU datapath stages (e.g. memory-read data to writeback) so a downstream stall never drops or duplicates a word.
- Gives full throughput: one word per cycle when downstream is ready.

---
 rtl/data_skid_reg.sv | 100 ++++++++++
 1 files changed

// File: rtl/data_skid_reg.sv
// Two-entry (main + skid) valid/ready pipeline register with synchronous flush.
// Optional saturating stall counter enabled by defining DATA_SKID_STALL_CNT_EN.
module data_skid_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef DATA_SKID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             acc, fire;

  // Handshake outputs depend only on registered state, never on out_ready or in_data.
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;

  assign acc  = in_valid & in_ready;
  assign fire = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (acc) begin
            main_next  = in_data;
            state_next = ONE;
          end
        end
        ONE: begin
          if (acc && fire) begin
            main_next = in_data;
          end else if (acc) begin
            skid_next  = in_data;
            state_next = FULL;
          end else if (fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            main_next  = skid_reg;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
      main_reg  <= RESET_VALUE;
      skid_reg  <= RESET_VALUE;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

`ifdef DATA_SKID_STALL_CNT_EN
  // Saturates rather than wraps; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
